// File: rtl/flow_downsize.sv
// rtl/flow_downsize.sv - wide-to-narrow valid/ready stream converter with per-word beat count
module flow_downsize #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 0,
    localparam int N        = IN_W / OUT_W,
    localparam int LW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             src_val,
    output logic             src_rdy,
    input  logic [IN_W-1:0]  src_data,
    input  logic [LW-1:0]    src_len,
    output logic             dst_val,
    input  logic             dst_rdy,
    output logic [OUT_W-1:0] dst_data,
    output logic             dst_last
);

    localparam logic [LW-1:0] LAST_IDX = LW'(N - 1);

    logic [IN_W-1:0]  hold_q, hold_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic             val_q, val_d;
    logic             last_q, last_d;
    logic [OUT_W-1:0] data_q, data_d;

    logic             acc_in;
    logic             acc_out;
    logic [LW-1:0]    idx_inc;
    logic [LW-1:0]    len_clamped;

    // Slice k of a word, honouring the configured beat order.
    function automatic logic [OUT_W-1:0] beat_of(input logic [IN_W-1:0] w,
                                                 input logic [LW-1:0]   k);
        logic [IN_W-1:0] s;
        int              sh;
        if (MSB_FIRST != 0) begin
            sh = (N - 1 - int'(k)) * OUT_W;
        end else begin
            sh = int'(k) * OUT_W;
        end
        s = w >> sh;
        return s[OUT_W-1:0];
    endfunction

    // A length beyond the last slice can only arise when N is not a power of two.
    generate
        if (N == (1 << LW)) begin : g_len_pow2
            assign len_clamped = src_len;
        end else begin : g_len_clamp
            assign len_clamped = (src_len > LAST_IDX) ? LAST_IDX : src_len;
        end
    endgenerate

    // Ready whenever idle or the final beat of the current word leaves this cycle.
    assign src_rdy  = cfg_en & (~val_q | (dst_rdy & last_q));
    assign acc_in   = src_val & src_rdy;
    assign acc_out  = val_q & dst_rdy;
    assign idx_inc  = idx_q + LW'(1);

    assign dst_val  = val_q;
    assign dst_data = data_q;
    assign dst_last = last_q;

    // Next-state: disable clears, load beats retire, then advance, then retire.
    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        len_d  = len_q;
        val_d  = val_q;
        last_d = last_q;
        data_d = data_q;
        if (!cfg_en) begin
            idx_d  = '0;
            len_d  = '0;
            val_d  = 1'b0;
            last_d = 1'b0;
            data_d = '0;
        end else if (acc_in) begin
            hold_d = src_data;
            len_d  = len_clamped;
            idx_d  = '0;
            val_d  = 1'b1;
            data_d = beat_of(src_data, '0);
            last_d = (len_clamped == '0);
        end else if (acc_out && !last_q) begin
            idx_d  = idx_inc;
            data_d = beat_of(hold_q, idx_inc);
            last_d = (idx_inc == len_q);
        end else if (acc_out) begin
            val_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
            len_q  <= '0;
            val_q  <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
            len_q  <= len_d;
            val_q  <= val_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

endmodule
